sdram_arbiter: RTL
==================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter BURST_LEN, 512, data beats per burst; SHALL equal the SDRAM controller full-page length.
REQ-002 Parameter ADDR_W, 15, row/bank address width: {row[12:0], bank[1:0]}.
REQ-003 Parameter DATA_W, 16, data word width.
REQ-004 clk  in  1  system clock, shared with the SDRAM controller.
REQ-005 rst_n  in  1  asynchronous reset, active-low.
REQ-006 wr_req / wr_addr  in  1 / ADDR_W  write-port burst request and target row/bank.
REQ-007 wr_ack / wr_done  out  1 / 1  write grant pulse; burst-complete pulse.
REQ-008 wr_data  in  DATA_W  write-port data; wr_data_req  out  1  consume strobe.
REQ-009 rd_req / rd_addr  in  1 / ADDR_W  read-port burst request and target row/bank.
REQ-010 rd_ack / rd_done  out  1 / 1  read grant pulse; burst-complete pulse.
REQ-011 rd_data  out  DATA_W  read data; rd_data_valid  out  1  qualifies rd_data.
REQ-012 ctl_ready  in  1  controller idle; ctl_rw_en / ctl_rw  out  1 / 1  one-cycle request, 1=read.
REQ-013 ctl_addr  out  ADDR_W  burst row/bank to the controller.
REQ-014 ctl_wdata  out  DATA_W; ctl_wdata_req  in  1  controller write-beat strobe.
REQ-015 ctl_rdata  in  DATA_W; ctl_rdata_valid  in  1  controller read-beat strobe.
REQ-016 busy  out  1; grant  out  2  (01=write port, 10=read port, 00=none).

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, XFER, DRAIN.
REQ-018 IDLE: when ctl_ready=1 and wr_req or rd_req is high, the arbiter SHALL select one port, register its address into ctl_addr, set grant, and enter ISSUE next cycle.
REQ-019 ISSUE: ctl_rw_en and the selected port's ack SHALL be high for exactly one cycle, with ctl_rw=1 for the read port and 0 for the write port; next state is XFER.
REQ-020 XFER: a 10-bit beat counter SHALL increment on each ctl_wdata_req (write grant) or ctl_rdata_valid (read grant).
REQ-021 On the beat making count==BURST_LEN, the granted port's done SHALL pulse one cycle later, and the FSM SHALL enter DRAIN.
REQ-022 DRAIN: the FSM SHALL wait for ctl_ready=0 followed by ctl_ready=1, or for ctl_ready=1 held 2 consecutive cycles, before returning to IDLE, so that no request is issued during precharge.
REQ-023 ctl_wdata SHALL equal wr_data combinationally; wr_data_req SHALL equal ctl_wdata_req AND grant[0].
REQ-024 rd_data SHALL equal ctl_rdata; rd_data_valid SHALL equal ctl_rdata_valid AND grant[1].
REQ-025 Strobes arriving outside XFER, or beyond BURST_LEN beats, SHALL be ignored by the counter and SHALL NOT be forwarded.
REQ-026 Requests SHALL be sampled only in IDLE; a req dropped before ack SHALL be treated as withdrawn, with no ack issued.
REQ-027 Requesters SHALL hold req and addr stable until ack; req still high after done SHALL be treated as a new request.
REQ-028 busy SHALL be 1 in every state except IDLE.

Reset
REQ-029 While rst_n=0: FSM=IDLE, counter=0, grant=00, busy=0, and all ack/done/ctl_rw_en/ctl_rw=0, ctl_addr=0.
REQ-030 Reset asserted mid-burst SHALL abort immediately with no done pulse; the first post-reset issue SHALL wait for ctl_ready=1.

Configuration
REQ-031 With SDRAM_ARB_RR_EN defined, simultaneous requests SHALL alternate ports, with the last-granted port losing the tie; the last-grant register resets to the write port, so the read port wins the first tie.
REQ-032 Without SDRAM_ARB_RR_EN, the read port SHALL always win simultaneous requests (fixed display priority).

Verification
REQ-033 Single write: wr_req, wr_addr=15'h1A5, ctl_ready=1 -> one-cycle ctl_rw_en with ctl_rw=0, ctl_addr=1A5, wr_ack; 512 forwarded wr_data_req; wr_done one cycle after beat 512.
REQ-034 Single read, rd_addr=15'h0003 -> ctl_rw=1; 512 rd_data_valid beats whose data matches ctl_rdata; rd_done; grant returns to 00 after DRAIN.
REQ-035 Simultaneous wr_req and rd_req held over three bursts -> RR build grants read, write, read; fixed build grants read, read, read.
REQ-036 Extra ctl_rdata_valid beat 513 and stray ctl_wdata_req pulses in IDLE -> not forwarded; counter unchanged.
REQ-037 rst_n pulsed low at beat 200 of a write -> all outputs reset, no wr_done; next request issues only after ctl_ready=1.
REQ-038 ctl_ready held 0 in IDLE with rd_req high -> no ctl_rw_en until ctl_ready=1.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: two-port (write / read) burst arbiter in front of a full-page
// SDRAM controller. A port is granted one BURST_LEN-beat burst at a time; beat
// strobes from the controller are forwarded only to the granted port and only
// while the burst is in progress.
//
// Build option: define SDRAM_ARB_RR_EN to alternate ports on simultaneous
// requests (the last-granted port loses the tie). Without it the read port
// always wins a tie, because display refresh must never starve.
module sdram_arbiter #(
    parameter int BURST_LEN = 512,
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              wr_ack,
    output logic              wr_done,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_data_req,

    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_done,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_data_valid,

    input  logic              ctl_ready,
    output logic              ctl_rw_en,
    output logic              ctl_rw,
    output logic [ADDR_W-1:0] ctl_addr,
    output logic [DATA_W-1:0] ctl_wdata,
    input  logic              ctl_wdata_req,
    input  logic [DATA_W-1:0] ctl_rdata,
    input  logic              ctl_rdata_valid,

    output logic              busy,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        XFER  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // Beat counter is 10 bits wide so a full 512-beat page fits with headroom.
    localparam int              CNT_W     = 10;
    localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);

    state_t              state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                wr_done_q, wr_done_d;
    logic                rd_done_q, rd_done_d;
    // DRAIN bookkeeping: saw_low marks a ready low phase (precharge seen),
    // rdy_seen marks one ready-high cycle already observed in DRAIN.
    logic                saw_low_q, saw_low_d;
    logic                rdy_seen_q, rdy_seen_d;

    logic                pick_rd;
    logic                in_window;
    logic                beat;

`ifdef SDRAM_ARB_RR_EN
    // 1 when the read port received the most recent grant.
    logic                last_rd_q, last_rd_d;

    // Tie-break: the port granted last time yields to the other one.
    always_comb begin
        pick_rd = rd_req & (~wr_req | ~last_rd_q);
    end
`else
    // Tie-break: read port has fixed priority.
    always_comb begin
        pick_rd = rd_req;
    end
`endif

    // Strobes count only inside XFER and only up to the burst length.
    assign in_window = (state_q == XFER) && (cnt_q < BURST_CNT);
    assign beat      = in_window &&
                       ((grant_q[0] && ctl_wdata_req) || (grant_q[1] && ctl_rdata_valid));

    // Next-state and next-register values for the arbitration FSM.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        wr_done_d  = 1'b0;
        rd_done_d  = 1'b0;
        saw_low_d  = saw_low_q;
        rdy_seen_d = rdy_seen_q;
`ifdef SDRAM_ARB_RR_EN
        last_rd_d  = last_rd_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d      = '0;
                saw_low_d  = 1'b0;
                rdy_seen_d = 1'b0;
                if (ctl_ready && (wr_req || rd_req)) begin
                    state_d = ISSUE;
                    if (pick_rd) begin
                        grant_d = 2'b10;
                        addr_d  = rd_addr;
`ifdef SDRAM_ARB_RR_EN
                        last_rd_d = 1'b1;
`endif
                    end else begin
                        grant_d = 2'b01;
                        addr_d  = wr_addr;
`ifdef SDRAM_ARB_RR_EN
                        last_rd_d = 1'b0;
`endif
                    end
                end
            end
            ISSUE: begin
                state_d = XFER;
            end
            XFER: begin
                if (beat) begin
                    cnt_d = cnt_q + 10'd1;
                    if ((cnt_q + 10'd1) == BURST_CNT) begin
                        wr_done_d = grant_q[0];
                        rd_done_d = grant_q[1];
                        state_d   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Leave only after the controller has visibly gone through
                // precharge (low then high) or has stayed ready for two cycles.
                if (!ctl_ready) begin
                    saw_low_d  = 1'b1;
                    rdy_seen_d = 1'b0;
                end else if (saw_low_q || rdy_seen_q) begin
                    state_d = IDLE;
                    grant_d = 2'b00;
                end else begin
                    rdy_seen_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 2'b00;
            end
        endcase
    end

    // FSM and datapath registers; asynchronous reset aborts any burst at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            addr_q     <= '0;
            cnt_q      <= '0;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            saw_low_q  <= 1'b0;
            rdy_seen_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            wr_done_q  <= wr_done_d;
            rd_done_q  <= rd_done_d;
            saw_low_q  <= saw_low_d;
            rdy_seen_q <= rdy_seen_d;
        end
    end

`ifdef SDRAM_ARB_RR_EN
    // Last-grant memory; starts at the write port so read wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_rd_q <= 1'b0;
        end else begin
            last_rd_q <= last_rd_d;
        end
    end
`endif

    assign busy      = (state_q != IDLE);
    assign grant     = grant_q;
    assign ctl_addr  = addr_q;
    assign ctl_rw_en = (state_q == ISSUE);
    assign ctl_rw    = grant_q[1];
    assign wr_ack    = (state_q == ISSUE) && grant_q[0];
    assign rd_ack    = (state_q == ISSUE) && grant_q[1];
    assign wr_done   = wr_done_q;
    assign rd_done   = rd_done_q;

    // Data paths are pure wires; only the strobes are gated by the grant.
    assign ctl_wdata     = wr_data;
    assign wr_data_req   = ctl_wdata_req && grant_q[0] && in_window;
    assign rd_data       = ctl_rdata;
    assign rd_data_valid = ctl_rdata_valid && grant_q[1] && in_window;

endmodule
